// File: rtl/qs_pkg.sv
// Shared types and constants for the quicksort stack arbiter slice.
package qs_pkg;
    localparam int QS_ARB_R        = 2;
    localparam int QS_STACK_RD_LAT = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLR   = 2'd2
    } qs_srt_arb_state_t;

    typedef logic [$clog2(QS_ARB_R)-1:0] qs_req_id_t;
endpackage

// File: rtl/qs_rr_arb.sv
// Round-robin arbiter: one-hot grant from a request mask; pointer moves past the winner on ack.
module qs_rr_arb #(
    parameter int R   = 2,
    parameter int IDW = (R > 1) ? $clog2(R) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic           ack,
    output logic [R-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);
    logic [IDW-1:0] ptr_r;
    logic           found;
    int             idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(ptr_r) + k) % R;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr_r <= '0;
        else if (ack)
            ptr_r <= (gnt_id == IDW'(R - 1)) ? '0 : gnt_id + IDW'(1);
    end
endmodule

// File: rtl/qs_srt_stack_arb.sv
// Shares one qs_srt_stack among R requesters: legal-only round-robin, one registered
// command per cycle, local occupancy tracking and pop-response routing by requester ID.
module qs_srt_stack_arb
    import qs_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 32,
    parameter int R = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [R-1:0]           req_vld,
    input  logic [R-1:0]           req_push,
    input  logic [R-1:0][W-1:0]    req_dat,
    output logic [R-1:0]           req_rdy,
    output logic [R-1:0]           rsp_vld,
    output logic [W-1:0]           rsp_dat,
    input  logic                   clr_req,
    output logic                   clr_done,
    output logic                   cmd_vld_r,
    output logic                   cmd_push_r,
    output logic                   cmd_clr_r,
    output logic [W-1:0]           cmd_push_dat_r,
    input  logic [W-1:0]           head_r,
    input  logic                   head_vld_r,
    input  logic                   cmd_err_w,
    output logic [$clog2(N+1)-1:0] occ_r,
    output logic                   err_r
);
    localparam int OW  = $clog2(N + 1);
    localparam int IDW = (R > 1) ? $clog2(R) : 1;

    qs_srt_arb_state_t state_r, state_nxt;
    logic              run_en, clr_go;
    logic [R-1:0]      legal, gnt;
    logic [IDW-1:0]    gnt_id;
    logic              acc, acc_pop;

    logic [IDW-1:0]    fifo_q [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fifo_cnt;
    logic              fifo_empty, fifo_pop;

    assign fifo_empty = (fifo_cnt == 3'd0);
    assign fifo_pop   = head_vld_r && !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_RUN;
        else      state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_RUN:   if (clr_req) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_nxt = ST_CLR;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Reset is folded into run_en so nothing is granted while rst is held low.
    always_comb begin
        run_en = (state_r == ST_RUN) && rst;
        clr_go = (state_r == ST_DRAIN) && fifo_empty;
    end

    always_comb begin
        for (int i = 0; i < R; i++)
            legal[i] = req_vld[i] && run_en &&
                       (req_push[i] ? (occ_r < OW'(N)) : (occ_r != '0));
    end

    qs_rr_arb #(.R(R), .IDW(IDW)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (legal),
        .ack    (acc),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_rdy = gnt;
    assign acc     = |gnt;
    assign acc_pop = acc && !req_push[gnt_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_vld_r      <= 1'b0;
            cmd_push_r     <= 1'b0;
            cmd_clr_r      <= 1'b0;
            cmd_push_dat_r <= '0;
            occ_r          <= '0;
            clr_done       <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            cmd_vld_r  <= acc;
            cmd_push_r <= acc && req_push[gnt_id];
            cmd_clr_r  <= clr_go;
            clr_done   <= (state_r == ST_CLR);
            if (acc)
                cmd_push_dat_r <= req_dat[gnt_id];
            if (clr_go)
                occ_r <= '0;
            else if (acc)
                occ_r <= req_push[gnt_id] ? occ_r + OW'(1) : occ_r - OW'(1);
            if (cmd_err_w || (head_vld_r && fifo_empty))
                err_r <= 1'b1;
        end
    end

    // At most 3 pops are ever in flight, so a 4-entry ID FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int k = 0; k < 4; k++) fifo_q[k] <= '0;
        end else begin
            if (acc_pop) begin
                fifo_q[wr_ptr] <= gnt_id;
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (fifo_pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({acc_pop, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_comb begin
        rsp_vld = '0;
        rsp_dat = '0;
        if (fifo_pop) begin
            rsp_vld[fifo_q[rd_ptr]] = 1'b1;
            rsp_dat                 = head_r;
        end
    end
endmodule

// File: doc/qs_srt_stack_arb.md
# qs_srt_stack_arb

Arbiter and sequencer sharing one `qs_srt_stack` instance between R requesters, e.g. the partition engine pushing sub-ranges and the sort engine popping work. It accepts push/pop requests over valid/ready handshakes, round-robins among legal requesters, and issues at most one registered command per cycle to the stack. It tracks stack occupancy locally so that no illegal command is ever issued. Pop data returns to the originating requester.

## Interface
- `N`, 16: stack depth; must match the stack instance.
- `W`, 32: data word width.
- `R`, 2: number of requesters, at least 2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_vld`  in  R  request valid, one bit per requester.
- `req_push`  in  R  request type: 1 = push, 0 = pop.
- `req_dat`  in  R×W  push data, packed per requester.
- `req_rdy`  out  R  request accepted in this cycle.
- `rsp_vld`  out  R  pop data valid; at most one bit set.
- `rsp_dat`  out  W  pop data, shared by all requesters.
- `clr_req`  in  1  single-cycle pulse that requests a stack flush.
- `clr_done`  out  1  single-cycle pulse when the flush completes.
- `cmd_vld_r`, `cmd_push_r`, `cmd_clr_r`  out  1 each  registered command to the stack.
- `cmd_push_dat_r`  out  W  registered push data to the stack.
- `head_r`  in  W  stack read data.
- `head_vld_r`  in  1  stack read data valid.
- `cmd_err_w`  in  1  stack error indication.
- `occ_r`  out  clog2(N+1)  local occupancy count.
- `err_r`  out  1  sticky error flag.

## Operation
- FSM states: RUN, DRAIN, CLR. Reset enters RUN.
- Legality mask, evaluated per requester:
  - A push is legal when `occ_r` < N.
  - A pop is legal when `occ_r` > 0.
- Arbitration:
  - Round-robin over requesters that have `req_vld` set and a legal request.
  - In RUN only; the grant is one-hot.
  - The priority pointer moves to winner+1 mod R after every acceptance.
  - It does not move when there is no acceptance.
- `req_rdy[i]` is 1 only for the granted requester in RUN. It is combinational from `req_vld`, `req_push` and state. Requesters must not make `req_vld` depend on `req_rdy`.
- Effects of an acceptance:
  - On the next edge, `cmd_vld_r`=1, `cmd_push_r`=`req_push[i]`, `cmd_push_dat_r`=`req_dat[i]`.
  - `occ_r` moves by ±1 on the same edge.
  - `cmd_vld_r` is 0 in every cycle with no acceptance.
- An illegal request is never granted. It stalls only its own requester; other legal requesters may still win.
- In-flight tracking:
  - A pop FIFO of requester IDs, depth 4, holds the ID of each accepted pop.
  - When `head_vld_r` is 1, the FIFO head ID is popped.
  - `rsp_vld[id]`=1 and `rsp_dat`=`head_r` in that same cycle, combinationally; there is no backpressure.
  - If `head_vld_r` arrives with the FIFO empty, `err_r` is set.
- Flush sequence:
  - `clr_req` in RUN moves the FSM to DRAIN. New grants stop from the next cycle; an acceptance in the `clr_req` cycle itself still completes.
  - DRAIN waits until the pop FIFO is empty, then moves to CLR.
  - CLR drives `cmd_clr_r`=1 for one cycle and sets `occ_r`=0. The next cycle pulses `clr_done` and returns to RUN.
  - `clr_req` outside RUN is ignored.
- `cmd_err_w`=1 sets `err_r`, which is cleared only by reset. It should never fire.

## Timing
- Reset values:
  - `req_rdy`=0, `rsp_vld`=0, `rsp_dat`=0, `clr_done`=0.
  - `cmd_vld_r`=0, `cmd_push_r`=0, `cmd_clr_r`=0, `cmd_push_dat_r`=0.
  - `occ_r`=0, `err_r`=0.
  - Pop FIFO empty, pointer at requester 0.
- Pop latency:
  - Accept at cycle t, `cmd_vld_r` at t+1, stack SRAM read at t+1, `head_vld_r` at t+3.
  - `rsp_vld` at t+3.
- Push then immediate pop of the same data is legal back-to-back, at one acceptance per cycle. Sustained throughput is one command per cycle.
- The pop FIFO never overflows: at most 3 pops are in flight.
- Reset mid-operation: in-flight responses are discarded; the stack is reset alongside.

## Structure
- The `qs_pkg` shared package holds:
  - `qs_srt_arb_state_t`, the FSM enum.
  - The requester-ID type of width clog2(R).
  - The constant `QS_STACK_RD_LAT` = 2, the cycles from `cmd_vld_r` to `head_vld_r`.
- One natural sub-module is `qs_rr_arb` (parameter R): request mask in, one-hot grant out, with an `ack` input that advances the pointer.
- The pop-ID FIFO is inline: a 4-entry register array with 2-bit pointers.

## Test plan
- R=2, empty stack; requester 0 pushes 0xA, 0xB, 0xC, then requester 1 pops three times. Required: `rsp_vld[1]` with `rsp_dat` = 0xC, 0xB, 0xA, each 3 cycles after its acceptance; `occ_r` ends at 0.
- Both requesters push continuously with N=16. Required: grants alternate 0,1,0,1; `occ_r` reaches 16; further pushes see `req_rdy`=0; `err_r` stays 0.
- At `occ_r`=0, requester 0 pops and requester 1 pushes 0x5. Required: only requester 1 is granted; requester 0 is then granted next cycle and receives 0x5.
- With `occ_r`=16, requester 0 pushes and requester 1 pops. Required: only the pop is granted; the push is accepted in the following cycle.
- Two pops in flight, then a `clr_req` pulse. Required: both responses are delivered, then `cmd_clr_r` pulses once, then `clr_done` pulses, `occ_r`=0, and no grants occur during DRAIN/CLR.
- Assert `rst` low mid-pop. Required: all outputs at reset values and no `rsp_vld` after release.
